// File: rtl/rr_arb_enc8.sv
// Eight-way round-robin arbiter with an encoded grant (index + enable) for a
// downstream 3-to-8 decoder. Bounded hold time and one dead cycle between owners.
module rr_arb_enc8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [7:0] req,
  output logic [2:0] grant_idx,
  output logic       grant_en
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [0:0]        state_q,     state_d;
  logic [2:0]        grant_idx_q, grant_idx_d;
  logic              grant_en_q,  grant_en_d;
  logic [2:0]        ptr_q,       ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;

  // Candidate slot gi is requester ptr+1+gi (mod 8): slot 0 has top priority.
  logic [7:0][2:0] cand_idx;
  logic [7:0]      cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign cand_idx[gi] = ptr_q + 3'(gi + 1);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  logic       pick_valid;
  logic [2:0] pick_idx;

  always_comb begin
    pick_valid = |cand_req;
    pick_idx   = cand_idx[0];
    for (int i = 7; i >= 0; i--) begin
      if (cand_req[i]) begin
        pick_idx = cand_idx[i];
      end
    end
  end

  logic owner_release;

  always_comb begin
    owner_release = !req[grant_idx_q] || !arb_en || (hold_cnt_q == HOLD_MAX);
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    grant_en_d  = grant_en_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        grant_en_d = 1'b0;
        if (arb_en && pick_valid) begin
          grant_idx_d = pick_idx;
          grant_en_d  = 1'b1;
          hold_cnt_d  = HOLD_W'(1);
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (owner_release) begin
          // grant_idx is left alone; the decoder is already masked by En=0.
          grant_en_d = 1'b0;
          ptr_d      = grant_idx_q;
          hold_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          grant_en_d = 1'b1;
          if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        grant_en_d = 1'b0;
        hold_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= 3'd0;
      grant_en_q  <= 1'b0;
      ptr_q       <= 3'd7;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      grant_en_q  <= grant_en_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign grant_en  = grant_en_q;

endmodule
